task2a_fsm: RTL and testbench

- RC4 key-scheduling (KSA) swap-phase controller; drives a 256x8 single-port S-memory.
- S-memory is pre-initialised with s[i]=i by an upstream block.
- On start, runs the swap loop for i=0..255: j=(j+s[i]+key[i mod 3]) mod 256, then swaps s[i] and s[j].
- Pulses finish when the loop completes; sits between the init FSM and the decrypt FSM in the ARC4 datapath.

---
 rtl/task2a_fsm_if.sv | 21 ++
 rtl/task2a_fsm.sv | 109 ++++++++++
 tb/tb_task2a_fsm.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/task2a_fsm_if.sv
// S-memory bus plus start/finish handshake for the RC4 KSA swap controller.
// master is the controller side, slave is the memory/host side.
interface task2a_fsm_if;
   logic        start;
   logic [23:0] secret_key;
   logic        finish;
   logic        wren;
   logic [7:0]  address;
   logic [7:0]  data;
   logic [7:0]  q;

   modport master (
      input  start, secret_key, q,
      output finish, wren, address, data
   );

   modport slave (
      output start, secret_key, q,
      input  finish, wren, address, data
   );
endinterface

// File: rtl/task2a_fsm.sv
// RC4 key-scheduling swap phase: for i=0..255, j+=s[i]+key[i%3], swap s[i]/s[j].
// Outputs are registered on entry to each state, so they hold for that whole state.
module task2a_fsm (
   input  logic         clock,
   input  logic         reset_n,
   task2a_fsm_if.master bus
);

   typedef enum logic [3:0] {
      StIdle, StRdI, StWtI, StLtI, StRdJ, StWtJ, StLtJ, StWrI, StWrJ, StNext, StDone
   } state_e;

   state_e      state_q;
   logic [7:0]  i_q, j_q, si_q, sj_q;
   logic [1:0]  kidx_q;
   logic [7:0]  addr_q, data_q;
   logic        wren_q, finish_q;
   logic [7:0]  key_byte;
   logic [7:0]  j_next;

   always_comb begin
      case (kidx_q)
         2'd0:    key_byte = bus.secret_key[23:16];
         2'd1:    key_byte = bus.secret_key[15:8];
         default: key_byte = bus.secret_key[7:0];
      endcase
   end

   assign j_next = j_q + bus.q + key_byte;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         i_q      <= 8'd0;
         j_q      <= 8'd0;
         si_q     <= 8'd0;
         sj_q     <= 8'd0;
         kidx_q   <= 2'd0;
         addr_q   <= 8'd0;
         data_q   <= 8'd0;
         wren_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               wren_q   <= 1'b0;
               finish_q <= 1'b0;
               if (bus.start) begin
                  i_q     <= 8'd0;
                  j_q     <= 8'd0;
                  kidx_q  <= 2'd0;
                  addr_q  <= 8'd0;
                  state_q <= StRdI;
               end
            end
            StRdI: state_q <= StWtI;
            StWtI: state_q <= StLtI;
            StLtI: begin
               si_q    <= bus.q;
               j_q     <= j_next;
               addr_q  <= j_next;
               state_q <= StRdJ;
            end
            StRdJ: state_q <= StWtJ;
            StWtJ: state_q <= StLtJ;
            StLtJ: begin
               sj_q    <= bus.q;
               addr_q  <= i_q;
               data_q  <= bus.q;
               wren_q  <= 1'b1;
               state_q <= StWrI;
            end
            StWrI: begin
               addr_q  <= j_q;
               data_q  <= si_q;
               wren_q  <= 1'b1;
               state_q <= StWrJ;
            end
            StWrJ: begin
               wren_q  <= 1'b0;
               state_q <= StNext;
            end
            StNext: begin
               // Stop after i=255 so the counter never wraps into a 257th pass.
               if (i_q == 8'd255) begin
                  finish_q <= 1'b1;
                  state_q  <= StDone;
               end else begin
                  i_q     <= i_q + 8'd1;
                  addr_q  <= i_q + 8'd1;
                  kidx_q  <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                  state_q <= StRdI;
               end
            end
            StDone: begin
               finish_q <= 1'b0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.address = addr_q;
   assign bus.data    = data_q;
   assign bus.wren    = wren_q;
   assign bus.finish  = finish_q;

endmodule

// File: tb/tb_task2a_fsm.sv
// Directed bench for task2a_fsm with a behavioural 256x8 RAM and an RC4 KSA reference.
module tb_task2a_fsm;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   task2a_fsm_if bus ();

   task2a_fsm dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // RAM model: registered address, write on the edge, q follows the registered address.
   logic [7:0] mem [256];
   logic [7:0] addr_r;
   logic       q_mode;
   logic [7:0] q_const;
   logic       init_req;
   logic       init_ff;

   assign bus.q = q_mode ? q_const : mem[addr_r];

   always @(posedge clock) begin
      addr_r <= bus.address;
      if (init_req) begin
         for (int k = 0; k < 256; k++) mem[k] <= init_ff ? 8'hFF : 8'(k);
      end else if (bus.wren) begin
         mem[bus.address] <= bus.data;
      end
   end

   logic [7:0] wr_addr [$];
   logic [7:0] wr_data [$];
   int         fin_cnt;
   int         x_cnt = 0;
   logic       mon_clr;

   always @(posedge clock) begin
      if (mon_clr) begin
         wr_addr.delete();
         wr_data.delete();
         fin_cnt = 0;
      end else begin
         if (bus.wren === 1'b1) begin
            wr_addr.push_back(bus.address);
            wr_data.push_back(bus.data);
         end
         if (bus.finish === 1'b1) fin_cnt++;
      end
      if (reset_n === 1'b1 && $isunknown({bus.wren, bus.finish, bus.address, bus.data}))
         x_cnt++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   logic [7:0] ref_s [256];
   logic [7:0] ref_j [256];

   task automatic ref_ksa(input logic [23:0] key);
      logic [7:0] j, kb, t;
      j = 8'd0;
      for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
      for (int k = 0; k < 256; k++) begin
         case (k % 3)
            0:       kb = key[23:16];
            1:       kb = key[15:8];
            default: kb = key[7:0];
         endcase
         j        = j + ref_s[k] + kb;
         ref_j[k] = j;
         t        = ref_s[k];
         ref_s[k] = ref_s[j];
         ref_s[j] = t;
      end
   endtask

   task automatic load_ram(input logic ff);
      @(negedge clock);
      init_ff  = ff;
      init_req = 1'b1;
      @(negedge clock);
      init_req = 1'b0;
   endtask

   task automatic clear_mon();
      @(negedge clock);
      mon_clr = 1'b1;
      @(negedge clock);
      mon_clr = 1'b0;
   endtask

   // Pulses start, optionally re-pulses it at cycle poke_at, waits for finish (bounded).
   task automatic run(input int poke_at, input string tag);
      int  cyc;
      logic seen;
      cyc  = 0;
      seen = 1'b0;
      @(negedge clock);
      bus.start = 1'b1;
      while (cyc < 2400 && !seen) begin
         @(posedge clock);
         #1;
         cyc++;
         if (cyc == 1) bus.start = 1'b0;
         if (poke_at != 0 && cyc == poke_at) bus.start = 1'b1;
         if (poke_at != 0 && cyc == poke_at + 1) bus.start = 1'b0;
         if (bus.finish === 1'b1) seen = 1'b1;
      end
      bus.start = 1'b0;
      check_eq({tag, "_fin_in_window"}, 32'(seen && cyc >= 2300 && cyc <= 2310), 32'd1);
      repeat (4) @(posedge clock);
      #1;
      check_eq({tag, "_fin_pulses"}, 32'(fin_cnt), 32'd1);
      check_eq({tag, "_wr_cycles"}, 32'(wr_addr.size()), 32'd512);
      check_eq({tag, "_idle_wren"}, 32'(bus.wren), 32'd0);
   endtask

   // Checks i addresses, j addresses against ref_j, and final RAM against ref_s.
   task automatic check_ksa(input string tag);
      int bad_seq, bad_mem, lim;
      bad_seq = 0;
      bad_mem = 0;
      lim = (wr_addr.size() >= 512) ? 256 : wr_addr.size() / 2;
      for (int k = 0; k < lim; k++) begin
         if (wr_addr[2*k] !== 8'(k) || wr_addr[2*k+1] !== ref_j[k]) bad_seq++;
      end
      for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad_mem++;
      check_eq({tag, "_addr_seq_bad"}, 32'(bad_seq), 32'd0);
      check_eq({tag, "_ram_bad"}, 32'(bad_mem), 32'd0);
   endtask

   // Constant-q runs: j advances by step every pass and all write data equals the constant.
   task automatic check_const(input string tag, input logic [7:0] step, input logic [7:0] val);
      int bad, lim;
      logic [7:0] jexp;
      bad  = 0;
      jexp = 8'd0;
      lim = (wr_addr.size() >= 512) ? 256 : wr_addr.size() / 2;
      for (int k = 0; k < lim; k++) begin
         jexp = jexp + step;
         if (wr_addr[2*k] !== 8'(k) || wr_addr[2*k+1] !== jexp) bad++;
         if (wr_data[2*k] !== val || wr_data[2*k+1] !== val) bad++;
      end
      check_eq({tag, "_seq_bad"}, 32'(bad), 32'd0);
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.start      = 1'b0;
      bus.secret_key = 24'h000000;
      q_mode         = 1'b1;
      q_const        = 8'h00;
      init_req       = 1'b0;
      init_ff        = 1'b0;
      mon_clr        = 1'b0;
      fin_cnt        = 0;
      #1;
      check_eq("rst_wren", 32'(bus.wren), 32'd0);
      check_eq("rst_finish", 32'(bus.finish), 32'd0);
      check_eq("rst_address", 32'(bus.address), 32'd0);
      check_eq("rst_data", 32'(bus.data), 32'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Constant q=0xAF, zero key: j steps by 0xAF.
      q_const = 8'hAF;
      clear_mon();
      run(0, "constAF");
      check_eq("constAF_wr0_addr", 32'(wr_addr[0]), 32'h00);
      check_eq("constAF_wr0_data", 32'(wr_data[0]), 32'hAF);
      check_eq("constAF_wr1_addr", 32'(wr_addr[1]), 32'hAF);
      check_eq("constAF_wr1_data", 32'(wr_data[1]), 32'hAF);
      check_eq("constAF_j1", 32'(wr_addr[3]), 32'h5E);
      check_eq("constAF_j2", 32'(wr_addr[5]), 32'h0D);
      check_const("constAF", 8'hAF, 8'hAF);

      // Real KSA with key 010203; a stray start mid-run must be ignored.
      q_mode         = 1'b0;
      bus.secret_key = 24'h010203;
      ref_ksa(24'h010203);
      load_ram(1'b0);
      clear_mon();
      run(100, "ksa");
      check_eq("ksa_j_i0", 32'(wr_addr[1]), 32'h01);
      // s[1] is 0 after the first swap, so j = 1 + 0 + 2.
      check_eq("ksa_j_i1", 32'(wr_addr[3]), 32'h03);
      check_ksa("ksa");

      // Fresh run afterwards must restart j from 0.
      load_ram(1'b0);
      clear_mon();
      run(0, "rerun");
      check_eq("rerun_j_i0", 32'(wr_addr[1]), 32'h01);
      check_ksa("rerun");

      // All-0xFF RAM and key: j wraps every step.
      bus.secret_key = 24'hFFFFFF;
      load_ram(1'b1);
      clear_mon();
      run(0, "allFF");
      check_eq("allFF_j_i0", 32'(wr_addr[1]), 32'hFE);
      check_const("allFF", 8'hFE, 8'hFF);

      // Async reset mid-run.
      bus.secret_key = 24'h010203;
      load_ram(1'b0);
      clear_mon();
      @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (500) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("abort_wren", 32'(bus.wren), 32'd0);
      check_eq("abort_finish", 32'(bus.finish), 32'd0);
      check_eq("abort_address", 32'(bus.address), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      clear_mon();
      repeat (60) @(posedge clock);
      #1;
      check_eq("abort_no_writes", 32'(wr_addr.size()), 32'd0);
      check_eq("abort_no_finish", 32'(fin_cnt), 32'd0);
      check_eq("no_x_outputs", 32'(x_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
